// File: rtl/chunked_seq_adder_if.sv
// chunked_seq_adder_if: start/busy/done handshake, operands and result of the chunked adder
interface chunked_seq_adder_if #(parameter int WIDTH = 32);
    logic             start;
    logic             sub;
    logic             carry_in;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             carry_out;
    logic             overflow;
    logic [WIDTH-1:0] sum;
    modport master (output start, sub, carry_in, x, y, input busy, done, carry_out, overflow, sum);
    modport slave (input start, sub, carry_in, x, y, output busy, done, carry_out, overflow, sum);
endinterface

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: WIDTH-bit add/subtract, CHUNK bits per clock through one ripple slice
module chunked_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input logic clk,
    input logic rst_n,
    chunked_seq_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] a, b, partial, next_partial;
    logic             c, cout, cmsb, last;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] s;
    // Operands shift right each slice so the active slice is always the low CHUNK bits
    assign {cout, s} = {1'b0, a[CHUNK-1:0]} + {1'b0, b[CHUNK-1:0]} + (CHUNK+1)'(c);
    assign cmsb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    assign next_partial = (partial >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
    assign last = k == KW'(NCHUNK - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            c             <= 1'b0;
            k             <= '0;
            partial       <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a        <= bus.x;
                    b        <= bus.sub ? ~bus.y : bus.y;
                    c        <= bus.carry_in ^ bus.sub;
                    k        <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
            end else begin
                a       <= a >> CHUNK;
                b       <= b >> CHUNK;
                c       <= cout;
                partial <= next_partial;
                k       <= last ? '0 : k + 1'b1;
                if (last) begin
                    bus.sum       <= next_partial;
                    bus.carry_out <= cout;
                    bus.overflow  <= cmsb ^ cout;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder: directed checks of the 32/4 adder plus an 8-bit sweep over CHUNK=1/2/8
module tb_chunked_seq_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    int lat, lat2, nb, seen;
    int l[3];
    logic [9:0] r[3];
    logic [7:0] xx8, yy8, bb8, es8;
    logic s8, c8, eco8, eov8;

    chunked_seq_adder_if #(.WIDTH(32)) m();
    chunked_seq_adder_if #(.WIDTH(8)) w1();
    chunked_seq_adder_if #(.WIDTH(8)) w2();
    chunked_seq_adder_if #(.WIDTH(8)) w8();
    chunked_seq_adder #(.WIDTH(32), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
    chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(w1));
    chunked_seq_adder #(.WIDTH(8), .CHUNK(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(w2));
    chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(w8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic st, input logic [7:0] xx, input logic [7:0] yy, input logic s, input logic c);
        w1.start = st; w1.x = xx; w1.y = yy; w1.sub = s; w1.carry_in = c;
        w2.start = st; w2.x = xx; w2.y = yy; w2.sub = s; w2.carry_in = c;
        w8.start = st; w8.x = xx; w8.y = yy; w8.sub = s; w8.carry_in = c;
    endtask

    task automatic op32(input string tag, input logic s, input logic [31:0] xx, input logic [31:0] yy,
                        input logic ci, input logic [31:0] es, input logic eco, input logic eov,
                        input logic disturb);
        int lt, bc;
        @(negedge clk);
        m.start = 1'b1; m.sub = s; m.x = xx; m.y = yy; m.carry_in = ci;
        @(negedge clk);
        m.start = 1'b0; m.x = 32'hFFFF_FFFF; m.y = 32'hFFFF_FFFF; m.sub = ~s; m.carry_in = ~ci;
        lt = 0;
        bc = 0;
        while (!m.done && lt < 40) begin
            if (m.busy) bc++;
            m.start = disturb && (lt == 2 || lt == 5);
            @(negedge clk);
            lt++;
        end
        m.start = 1'b0;
        chk({tag, "_latency"}, lt, 8);
        chk({tag, "_busy_cycles"}, bc, 8);
        chk({tag, "_busy_at_done"}, m.busy, 0);
        chk({tag, "_sum"}, m.sum, es);
        chk({tag, "_carry_out"}, m.carry_out, eco);
        chk({tag, "_overflow"}, m.overflow, eov);
    endtask

    initial begin
        m.start = 0; m.sub = 0; m.x = 0; m.y = 0; m.carry_in = 0;
        drive8(0, 0, 0, 0, 0);
        #12;
        chk("rst_busy", m.busy, 0);
        chk("rst_done", m.done, 0);
        chk("rst_sum", m.sum, 0);
        chk("rst_carry_out", m.carry_out, 0);
        chk("rst_overflow", m.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op32("inc_wrap", 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 0);
        op32("pos_ovf", 0, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 1, 0);
        op32("sub_neg", 1, 32'h5, 32'h7, 0, 32'hFFFF_FFFE, 0, 0, 0);
        op32("sub_borrow_in", 1, 32'h7, 32'h5, 1, 32'h1, 1, 0, 0);
        @(negedge clk);
        chk("done_one_cycle", m.done, 0);
        chk("hold_sum", m.sum, 32'h1);
        chk("hold_carry_out", m.carry_out, 1);
        op32("ignore_start", 0, 32'h1234_5678, 32'h1111_1111, 0, 32'h2345_6789, 0, 0, 1);

        // start held high: second op is accepted in the done cycle
        @(negedge clk);
        m.start = 1'b1; m.sub = 0; m.x = 32'd10; m.y = 32'd20; m.carry_in = 0;
        @(negedge clk);
        lat = 0;
        while (!m.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", lat, 8);
        chk("b2b_first_sum", m.sum, 32'd30);
        m.x = 32'd100; m.y = 32'd200;
        @(negedge clk);
        m.start = 1'b0;
        lat2 = 1;
        while (!m.done && lat2 < 40) begin
            @(negedge clk);
            lat2++;
        end
        chk("b2b_done_spacing", lat2, 9);
        chk("b2b_second_sum", m.sum, 32'd300);

        // abort mid-run after three slices
        @(negedge clk);
        m.start = 1'b1; m.x = 32'hAAAA_0000; m.y = 32'h1; m.sub = 0; m.carry_in = 0;
        @(negedge clk);
        m.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", m.busy, 0);
        chk("abort_done", m.done, 0);
        chk("abort_sum", m.sum, 0);
        chk("abort_carry_out", m.carry_out, 0);
        chk("abort_overflow", m.overflow, 0);
        seen = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (m.done || m.busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        op32("after_reset", 0, 32'h3, 32'h4, 0, 32'h7, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            xx8 = 8'($urandom);
            yy8 = 8'($urandom);
            s8 = 1'($urandom_range(0, 1));
            c8 = 1'($urandom_range(0, 1));
            bb8 = s8 ? ~yy8 : yy8;
            {eco8, es8} = {1'b0, xx8} + {1'b0, bb8} + 9'(c8 ^ s8);
            eov8 = (xx8[7] == bb8[7]) && (es8[7] != xx8[7]);
            @(negedge clk);
            drive8(1, xx8, yy8, s8, c8);
            @(negedge clk);
            drive8(0, ~xx8, ~yy8, ~s8, ~c8);
            l = '{-1, -1, -1};
            for (int t = 0; t < 12; t++) begin
                if (w1.done && l[0] < 0) begin l[0] = t; r[0] = {w1.carry_out, w1.overflow, w1.sum}; end
                if (w2.done && l[1] < 0) begin l[1] = t; r[1] = {w2.carry_out, w2.overflow, w2.sum}; end
                if (w8.done && l[2] < 0) begin l[2] = t; r[2] = {w8.carry_out, w8.overflow, w8.sum}; end
                @(negedge clk);
            end
            chk("w8c1_latency", l[0], 8);
            chk("w8c1_result", r[0], {eco8, eov8, es8});
            chk("w8c2_latency", l[1], 4);
            chk("w8c2_result", r[1], {eco8, eov8, es8});
            chk("w8c8_latency", l[2], 1);
            chk("w8c8_result", r[2], {eco8, eov8, es8});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
